data_mem: RTL and testbench
===========================

# data_mem

Synchronous word-addressed data memory for the single-cycle processor's memory stage. It stores 32-bit words, addressed by the 64-bit ALU result. It accepts a 64-bit store operand and returns a registered 32-bit load result. It sits between the ALU/register-file datapath and the write-back mux.

## Interface

- DEPTH, 64: number of 32-bit words (power of two, 2..1024).
- INIT_VAL, 32'h0000_0000: value loaded into every word and into `out` on reset.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  one clock; reset is asynchronous and active-low: `rst`=0 resets immediately; `rst`=1 means normal operation.
- A  input  64  byte address.
- B  input  64  store data; only B[31:0] is stored, B[63:32] is ignored.
- en  input  1  access enable; 0 means no read, no write, and `out` holds.
- rw  input  1  1 means read, 0 means write.
- out  output  32  registered read data.

## Operation

- Word index is A[log2(DEPTH)+1:2]. A[1:0] is ignored, so accesses are forced word-aligned.
- Address is in range when A[63:log2(DEPTH)+2] == 0.
- Read (en=1, rw=1): `out` <= mem[index] when in range, else 32'h0.
- Write (en=1, rw=0): mem[index] <= B[31:0] when in range, else no change. `out` holds its previous value during a write.
- en=0: memory and `out` are unchanged regardless of rw, A, B.
- Reset (rst=0): every mem word and `out` are set to INIT_VAL. While rst=0, reads and writes are blocked.
- Memory contents are undefined at power-up until the first reset. A bench must reset before the first access.

## Timing

- Read latency is 1 cycle. A and en/rw are sampled at posedge N, and `out` is valid after posedge N and stable until the next enabled read.
- Write takes effect at the posedge it is sampled. A read of the same word at posedge N+1 returns the new data.
- There is no same-cycle read/write conflict, because rw selects exactly one operation.
- Reset asserted mid-operation aborts the pending access. The write at that edge is not performed.
- Reset release is synchronous to the next posedge. The first access is honoured at the first posedge with rst=1.

## Configuration

- DATAMEM_RANGE_CHECK_EN defined: out-of-range addresses read 32'h0 and writes are dropped, as described above.
- DATAMEM_RANGE_CHECK_EN undefined: upper address bits are ignored. The index wraps modulo DEPTH, so every address maps to mem[index] for both read and write.

## Test plan

- Reset: rst=0 for 2 cycles with A=0, B=all ones, en=1, rw=1 -> out=32'h0 immediately and throughout. Release rst=1 and read A=0 -> out=32'h0.
- Write/read: rst=1, en=1, rw=0, A=64'h10, B=64'hFFFF_FFFF_DEAD_BEEF. Next cycle rw=1 -> out=32'hDEAD_BEEF one cycle later.
- Out of range, with DATAMEM_RANGE_CHECK_EN defined: read A=64'hFFFF_FFFF_FFFF_FFFF -> out=32'h0.
  - A write of 32'h1234_5678 to that address leaves mem[63] unchanged.
  - Without the macro, the same write lands in mem[63] and reads back 32'h1234_5678.
- Enable gating: after reading 32'hDEAD_BEEF, set en=0 and toggle rw, A and B for 4 cycles -> out stays 32'hDEAD_BEEF and memory is unchanged.
- Misalignment: write 32'hCAFE_0001 at A=64'h13 -> reading A=64'h10 returns 32'hCAFE_0001.
- Async reset mid-write: drop rst between edges during a write of 32'hAAAA_AAAA to A=64'h20 -> out goes to 32'h0 without a clock edge, and reading A=64'h20 afterwards returns 32'h0.

Source files
------------

// File: rtl/data_mem_if.sv
// rtl/data_mem_if.sv - access bus between the memory stage datapath and data_mem
interface data_mem_if;
    logic [63:0] A;
    logic [63:0] B;
    logic        en;
    logic        rw;
    logic [31:0] out;

    modport master (output A, B, en, rw, input out);
    modport slave  (input A, B, en, rw, output out);
endinterface

// File: rtl/data_mem.sv
// rtl/data_mem.sv - word-addressed data memory with registered load result
// Optional DATAMEM_RANGE_CHECK_EN: out-of-range reads return zero and writes drop.
module data_mem #(
    parameter int          DEPTH    = 64,
    parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     rst,
    data_mem_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [31:0]   out_q;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          unused_bits;

    assign idx = bus.A[AW+1:2];

`ifdef DATAMEM_RANGE_CHECK_EN
    assign in_range = (bus.A[63:AW+2] == '0);
`else
    // Upper address bits ignored: the index wraps modulo DEPTH.
    assign in_range = 1'b1;
`endif

    assign unused_bits = ^{bus.A[63:AW+2], bus.A[1:0], bus.B[63:32]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT_VAL;
            end
            out_q <= INIT_VAL;
        end else if (bus.en) begin
            if (bus.rw) begin
                out_q <= in_range ? mem[idx] : 32'h0;
            end else if (in_range) begin
                mem[idx] <= bus.B[31:0];
            end
        end
    end

    assign bus.out = out_q;
endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - directed self-checking bench for data_mem
module tb_data_mem;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;

    data_mem_if bus ();

    data_mem #(.DEPTH(64), .INIT_VAL(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            passed++;
    endtask

    task automatic access(input logic e, input logic r, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        bus.en = e;
        bus.rw = r;
        bus.A  = a;
        bus.B  = b;
        @(posedge clk);
        #1;
    endtask

`ifdef DATAMEM_RANGE_CHECK_EN
    localparam logic [31:0] OOR_EXP = 32'h0;
`else
    localparam logic [31:0] OOR_EXP = 32'h1234_5678;
`endif

    initial begin
        rst    = 1'b1;
        bus.en = 1'b1;
        bus.rw = 1'b1;
        bus.A  = 64'h0;
        bus.B  = '1;
        #2 rst = 1'b0;
        #1 check("reset_immediate", bus.out, 32'h0);
        access(1'b1, 1'b1, 64'h0, '1);
        check("reset_hold_1", bus.out, 32'h0);
        access(1'b1, 1'b1, 64'h0, '1);
        check("reset_hold_2", bus.out, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        access(1'b1, 1'b1, 64'h0, '1);
        check("read_after_reset", bus.out, 32'h0);

        access(1'b1, 1'b0, 64'h10, 64'hFFFF_FFFF_DEAD_BEEF);
        check("out_holds_on_write", bus.out, 32'h0);
        access(1'b1, 1'b1, 64'h10, 64'h0);
        check("write_read", bus.out, 32'hDEAD_BEEF);

        for (int i = 0; i < 4; i++) begin
            access(1'b0, i[0], (i[1] ? 64'h20 : 64'h10), {32'h0, 32'h5555_0000 | i});
            check("en_gate_out", bus.out, 32'hDEAD_BEEF);
        end
        access(1'b1, 1'b1, 64'h20, 64'h0);
        check("en_gate_mem_20", bus.out, 32'h0);
        access(1'b1, 1'b1, 64'h10, 64'h0);
        check("en_gate_mem_10", bus.out, 32'hDEAD_BEEF);

        access(1'b1, 1'b0, 64'h13, 64'h0000_0000_CAFE_0001);
        check("misalign_write_hold", bus.out, 32'hDEAD_BEEF);
        access(1'b1, 1'b1, 64'h10, 64'h0);
        check("misalign_read_10", bus.out, 32'hCAFE_0001);
        access(1'b1, 1'b1, 64'h12, 64'h0);
        check("misalign_read_12", bus.out, 32'hCAFE_0001);

        access(1'b1, 1'b1, '1, 64'h0);
        check("oor_read_before", bus.out, 32'h0);
        access(1'b1, 1'b0, '1, 64'h0000_0000_1234_5678);
        access(1'b1, 1'b1, 64'hFC, 64'h0);
        check("oor_mem63", bus.out, OOR_EXP);
        access(1'b1, 1'b1, '1, 64'h0);
        check("oor_read_after", bus.out, OOR_EXP);
        access(1'b1, 1'b1, 64'h0, 64'h0);
        check("oor_other_word", bus.out, 32'h0);

        access(1'b1, 1'b1, 64'h10, 64'h0);
        check("pre_reset_read", bus.out, 32'hCAFE_0001);
        @(negedge clk);
        bus.en = 1'b1;
        bus.rw = 1'b0;
        bus.A  = 64'h20;
        bus.B  = 64'h0000_0000_AAAA_AAAA;
        #2 rst = 1'b0;
        #1 check("async_reset_out", bus.out, 32'h0);
        @(posedge clk);
        #1 check("async_reset_hold", bus.out, 32'h0);
        @(negedge clk);
        rst    = 1'b1;
        bus.en = 1'b0;
        access(1'b1, 1'b1, 64'h20, 64'h0);
        check("aborted_write", bus.out, 32'h0);
        access(1'b1, 1'b1, 64'h10, 64'h0);
        check("reset_cleared_mem", bus.out, 32'h0);
        access(1'b1, 1'b0, 64'h20, 64'h0000_0000_AAAA_AAAA);
        access(1'b1, 1'b1, 64'h20, 64'h0);
        check("write_after_reset", bus.out, 32'hAAAA_AAAA);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
